// File: rtl/ahb_master_mux.sv
// rtl/ahb_master_mux.sv - AHB master mux: HMASTER-steered address phase, registered data-phase owner, response routing
// Optional macro AHB_MUX_ERR_CANCEL_EN: force the erroring owner's next HTRANS to IDLE during a two-cycle response.
module ahb_master_mux #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_M  = 4
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [1:0]              HMASTER,
  input  logic [NUM_M*ADDR_W-1:0] M_HADDR,
  input  logic [NUM_M*2-1:0]      M_HTRANS,
  input  logic [NUM_M-1:0]        M_HWRITE,
  input  logic [NUM_M*3-1:0]      M_HSIZE,
  input  logic [NUM_M*3-1:0]      M_HBURST,
  input  logic [NUM_M*DATA_W-1:0] M_HWDATA,
  input  logic                    HREADY,
  input  logic [1:0]              HRESP,
  output logic [ADDR_W-1:0]       HADDR,
  output logic [1:0]              HTRANS,
  output logic                    HWRITE,
  output logic [2:0]              HSIZE,
  output logic [2:0]              HBURST,
  output logic [DATA_W-1:0]       HWDATA,
  output logic [NUM_M*2-1:0]      M_HRESP,
  output logic [1:0]              HMASTER_D,
  output logic                    DP_ACTIVE
);

  localparam logic [1:0] DP_IDLE   = 2'd0;
  localparam logic [1:0] DP_XFER   = 2'd1;
  localparam logic [1:0] DP_RESP2  = 2'd2;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  logic [ADDR_W-1:0] haddr_a  [NUM_M];
  logic [1:0]        htrans_a [NUM_M];
  logic [2:0]        hsize_a  [NUM_M];
  logic [2:0]        hburst_a [NUM_M];
  logic [DATA_W-1:0] hwdata_a [NUM_M];

  logic [1:0] dp_master_q, dp_master_d;
  logic       dp_valid_q, dp_valid_d;
  logic       dp_write_q, dp_write_d;
  logic [1:0] state_q, state_d;
  logic [1:0] resp_code_q, resp_code_d;
  logic       cancel;

  always_comb begin
    for (int i = 0; i < NUM_M; i++) begin
      haddr_a[i]  = M_HADDR[i*ADDR_W +: ADDR_W];
      htrans_a[i] = M_HTRANS[i*2 +: 2];
      hsize_a[i]  = M_HSIZE[i*3 +: 3];
      hburst_a[i] = M_HBURST[i*3 +: 3];
      hwdata_a[i] = M_HWDATA[i*DATA_W +: DATA_W];
    end
  end

`ifdef AHB_MUX_ERR_CANCEL_EN
  logic err_cycle;
  // Both cycles of a non-OKAY response; only the owner that caused it is cancelled.
  assign err_cycle = (state_q == DP_RESP2) ||
                     ((state_q == DP_XFER) && !HREADY && (HRESP != RESP_OKAY));
  assign cancel    = err_cycle && (HMASTER == dp_master_q);
`else
  assign cancel = 1'b0;
`endif

  assign HADDR  = haddr_a[HMASTER];
  assign HTRANS = cancel ? 2'b00 : htrans_a[HMASTER];
  assign HWRITE = M_HWRITE[HMASTER];
  assign HSIZE  = hsize_a[HMASTER];
  assign HBURST = hburst_a[HMASTER];

  always_comb begin
    dp_master_d = dp_master_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    state_d     = state_q;
    resp_code_d = resp_code_q;
    if (HREADY) begin
      // The driven HTRANS (after any cancel) decides whether a data phase follows.
      dp_master_d = HMASTER;
      dp_valid_d  = HTRANS[1];
      dp_write_d  = HWRITE;
      state_d     = HTRANS[1] ? DP_XFER : DP_IDLE;
    end else if ((state_q == DP_XFER) && (HRESP != RESP_OKAY)) begin
      state_d     = DP_RESP2;
      resp_code_d = HRESP;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_master_q <= 2'd0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      state_q     <= DP_IDLE;
      resp_code_q <= RESP_OKAY;
    end else begin
      dp_master_q <= dp_master_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      state_q     <= state_d;
      resp_code_q <= resp_code_d;
    end
  end

  assign HMASTER_D = dp_master_q;
  assign DP_ACTIVE = dp_valid_q;
  assign HWDATA    = (dp_valid_q && dp_write_q) ? hwdata_a[dp_master_q] : '0;

  // Second response cycle replays the captured code even if the slave misbehaves.
  always_comb begin
    M_HRESP = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (dp_valid_q && (dp_master_q == i[1:0])) begin
        M_HRESP[i*2 +: 2] = (state_q == DP_RESP2) ? resp_code_q : HRESP;
      end
    end
  end

endmodule

// File: tb/tb_ahb_master_mux.sv
// tb/tb_ahb_master_mux.sv - directed vector table plus randomized model comparison for ahb_master_mux
module tb_ahb_master_mux;

  logic         HCLK;
  logic         HRESET;
  logic [1:0]   HMASTER;
  logic [127:0] M_HADDR;
  logic [7:0]   M_HTRANS;
  logic [3:0]   M_HWRITE;
  logic [11:0]  M_HSIZE;
  logic [11:0]  M_HBURST;
  logic [127:0] M_HWDATA;
  logic         HREADY;
  logic [1:0]   HRESP;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic         HWRITE;
  logic [2:0]   HSIZE;
  logic [2:0]   HBURST;
  logic [31:0]  HWDATA;
  logic [7:0]   M_HRESP;
  logic [1:0]   HMASTER_D;
  logic         DP_ACTIVE;

  ahb_master_mux dut (
    .HCLK(HCLK), .HRESET(HRESET), .HMASTER(HMASTER),
    .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE),
    .M_HSIZE(M_HSIZE), .M_HBURST(M_HBURST), .M_HWDATA(M_HWDATA),
    .HREADY(HREADY), .HRESP(HRESP),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .M_HRESP(M_HRESP),
    .HMASTER_D(HMASTER_D), .DP_ACTIVE(DP_ACTIVE)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

`ifdef AHB_MUX_ERR_CANCEL_EN
  localparam bit CANCEL = 1'b1;
`else
  localparam bit CANCEL = 1'b0;
`endif

  localparam logic [1:0] IDL = 2'b00, NS = 2'b10, SQ = 2'b11;
  localparam logic [1:0] OK = 2'b00, ERR = 2'b01, RTY = 2'b10;
  localparam logic [2:0] NONE = 3'd4;
  localparam logic [1:0] CX_SQ = CANCEL ? 2'b00 : SQ;
  localparam logic [1:0] CX_NS = CANCEL ? 2'b00 : NS;

  typedef struct {
    bit       rst;
    bit [1:0] hm;
    bit [1:0] tr;
    bit       wr;
    bit       rdy;
    bit [1:0] resp;
    bit [1:0] e_hmd;
    bit       e_act;
    bit [2:0] e_wsel;
    bit [7:0] e_mresp;
    bit [1:0] e_tr;
  } vec_t;

  vec_t        tbl [20];
  logic [31:0] addr_c  [4];
  logic [31:0] wdata_c [4];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the data phase and whether a two-cycle response is underway.
  int       md_owner;
  bit       md_valid;
  bit       md_write;
  bit       md_second;
  bit [1:0] md_code;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_cancel();
    bit in_err;
    in_err = md_valid && (md_second || (!HREADY && HRESP != OK));
    return CANCEL && in_err && (md_owner == int'(HMASTER));
  endfunction

  function automatic logic [1:0] model_trans();
    int hm = HMASTER;
    return model_cancel() ? 2'b00 : M_HTRANS[hm*2 +: 2];
  endfunction

  task automatic model_step();
    int hm = HMASTER;
    logic [1:0] t;
    t = model_trans();
    if (HRESET) begin
      md_owner = 0; md_valid = 0; md_write = 0; md_second = 0; md_code = OK;
    end else if (HREADY) begin
      md_owner  = hm;
      md_valid  = (t == NS) || (t == SQ);
      md_write  = M_HWRITE[hm];
      md_second = 0;
    end else if (md_valid && !md_second && HRESP != OK) begin
      md_second = 1;
      md_code   = HRESP;
    end
  endtask

  task automatic check_model();
    int hm = HMASTER;
    logic [7:0]  e_mresp;
    logic [31:0] e_wdata;
    e_mresp = '0;
    if (md_valid) e_mresp[md_owner*2 +: 2] = md_second ? md_code : HRESP;
    e_wdata = (md_valid && md_write) ? M_HWDATA[md_owner*32 +: 32] : 32'h0;
    check("rnd_haddr",   HADDR,     M_HADDR[hm*32 +: 32]);
    check("rnd_htrans",  {30'b0, HTRANS}, {30'b0, model_trans()});
    check("rnd_ctrl",    {25'b0, HWRITE, HSIZE, HBURST},
          {25'b0, M_HWRITE[hm], M_HSIZE[hm*3 +: 3], M_HBURST[hm*3 +: 3]});
    check("rnd_hwdata",  HWDATA,    e_wdata);
    check("rnd_mresp",   {24'b0, M_HRESP}, {24'b0, e_mresp});
    check("rnd_owner",   {29'b0, DP_ACTIVE, HMASTER_D}, {29'b0, md_valid, 2'(md_owner)});
  endtask

  task automatic apply_row(input vec_t r);
    HRESET   = r.rst;
    HMASTER  = r.hm;
    M_HTRANS = '0;
    M_HTRANS[r.hm*2 +: 2] = r.tr;
    M_HWRITE = {4{r.wr}};
    HREADY   = r.rdy;
    HRESP    = r.resp;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      addr_c[i]  = 32'h100 * i;
      wdata_c[i] = 32'hDA7A_0000 + i;
      M_HADDR[i*32 +: 32]  = addr_c[i];
      M_HWDATA[i*32 +: 32] = wdata_c[i];
      M_HSIZE[i*3 +: 3]    = 3'(i);
      M_HBURST[i*3 +: 3]   = 3'(3 - i);
    end

    //          rst hm tr     wr rdy resp  hmd act wsel  mresp             tr
    tbl[0]  = '{1, 2, NS,    0, 1, OK,  0, 0,    NONE, 8'h00,            NS};
    tbl[1]  = '{0, 2, NS,    0, 0, OK,  0, 0,    NONE, 8'h00,            NS};
    tbl[2]  = '{0, 2, NS,    1, 1, OK,  0, 0,    NONE, 8'h00,            NS};
    tbl[3]  = '{0, 1, NS,    1, 1, OK,  2, 1,    3'd2, 8'h00,            NS};
    tbl[4]  = '{0, 3, NS,    0, 0, OK,  1, 1,    3'd1, 8'h00,            NS};
    tbl[5]  = '{0, 3, NS,    0, 0, OK,  1, 1,    3'd1, 8'h00,            NS};
    tbl[6]  = '{0, 3, NS,    0, 1, OK,  1, 1,    3'd1, 8'h00,            NS};
    tbl[7]  = '{0, 0, SQ,    0, 1, ERR, 3, 1,    NONE, 8'h40,            SQ};
    tbl[8]  = '{0, 0, SQ,    0, 0, ERR, 0, 1,    NONE, 8'h01,            CX_SQ};
    tbl[9]  = '{0, 0, SQ,    0, 1, ERR, 0, 1,    NONE, 8'h01,            CX_SQ};
    tbl[10] = '{0, 1, IDL,   0, 1, ERR, 0, !CANCEL, NONE, CANCEL ? 8'h00 : 8'h01, IDL};
    tbl[11] = '{0, 2, NS,    1, 1, ERR, 1, 0,    NONE, 8'h00,            NS};
    tbl[12] = '{0, 2, IDL,   0, 0, OK,  2, 1,    3'd2, 8'h00,            IDL};
    tbl[13] = '{1, 2, IDL,   0, 0, OK,  2, 1,    3'd2, 8'h00,            IDL};
    tbl[14] = '{0, 0, IDL,   0, 0, OK,  0, 0,    NONE, 8'h00,            IDL};
    tbl[15] = '{0, 1, NS,    0, 1, OK,  0, 0,    NONE, 8'h00,            NS};
    tbl[16] = '{0, 1, NS,    0, 0, RTY, 1, 1,    NONE, 8'h08,            CX_NS};
    tbl[17] = '{0, 1, NS,    0, 0, OK,  1, 1,    NONE, 8'h08,            CX_NS};
    tbl[18] = '{0, 2, NS,    1, 1, RTY, 1, 1,    NONE, 8'h08,            NS};
    tbl[19] = '{0, 2, IDL,   0, 1, OK,  2, 1,    3'd2, 8'h00,            IDL};

    md_owner = 0; md_valid = 0; md_write = 0; md_second = 0; md_code = OK;
    apply_row(tbl[0]);
    model_step();

    for (int r = 0; r < 20; r++) begin
      @(negedge HCLK);
      apply_row(tbl[r]);
      #1;
      check($sformatf("row%0d_haddr", r),  HADDR, addr_c[tbl[r].hm]);
      check($sformatf("row%0d_htrans", r), {30'b0, HTRANS}, {30'b0, tbl[r].e_tr});
      check($sformatf("row%0d_hmaster_d", r), {30'b0, HMASTER_D}, {30'b0, tbl[r].e_hmd});
      check($sformatf("row%0d_dp_active", r), {31'b0, DP_ACTIVE}, {31'b0, tbl[r].e_act});
      check($sformatf("row%0d_hwdata", r), HWDATA,
            (tbl[r].e_wsel == NONE) ? 32'h0 : wdata_c[tbl[r].e_wsel[1:0]]);
      check($sformatf("row%0d_m_hresp", r), {24'b0, M_HRESP}, {24'b0, tbl[r].e_mresp});
      model_step();
    end

    for (int c = 0; c < 400; c++) begin
      @(negedge HCLK);
      HRESET   = ($urandom_range(0, 31) == 0);
      HMASTER  = 2'($urandom);
      M_HADDR  = {$urandom, $urandom, $urandom, $urandom};
      M_HWDATA = {$urandom, $urandom, $urandom, $urandom};
      M_HTRANS = 8'($urandom);
      M_HWRITE = 4'($urandom);
      M_HSIZE  = 12'($urandom);
      M_HBURST = 12'($urandom);
      HREADY   = ($urandom_range(0, 3) != 0);
      HRESP    = ($urandom_range(0, 1) == 0) ? OK : 2'($urandom);
      #1;
      check_model();
      model_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
